// File: rtl/echo_delay.sv
// Circular-buffer delay line: one sample written and one delayed sample read per i_en strobe, 2-cycle latency.
// Optional feedback echo path (write = sat(din + delayed >>> FB_SHIFT)) enabled by defining ECHO_DELAY_FEEDBACK_EN.
module echo_delay #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int FB_SHIFT   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [WIDTH-1:0]      i_din,
  input  logic [ADDR_WIDTH-1:0] i_offset,
  output logic [WIDTH-1:0]      o_dout,
  output logic                  o_dout_valid,
  output logic                  o_primed
);

  localparam logic [ADDR_WIDTH-1:0] FILL_MAX = '1;

  if (FB_SHIFT < 0 || FB_SHIFT >= WIDTH) begin : g_bad_fb_shift
    $error("echo_delay: FB_SHIFT must be in [0, WIDTH-1]");
  end

  logic [WIDTH-1:0]      r_mem [2**ADDR_WIDTH];
  logic [WIDTH-1:0]      r_ram_q;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_fill;
  logic                  r_s1_vld;
  logic [WIDTH-1:0]      r_s1_din;
  logic [ADDR_WIDTH-1:0] r_s1_ptr;
  logic                  r_s1_primed;
  logic                  r_s1_bypass;
  logic                  r_fwd_hit;
  logic [WIDTH-1:0]      r_fwd_dat;

  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic                  w_primed_now;
  logic                  w_wr_en;
  logic [WIDTH-1:0]      w_rdata;
  logic [WIDTH-1:0]      w_rd_muted;
  logic [WIDTH-1:0]      w_wdata;

  assign w_rd_addr    = r_wr_ptr - i_offset;
  assign w_primed_now = (i_offset == '0) || (r_fill >= i_offset);
  assign w_wr_en      = r_s1_vld && !i_rst;
  // The RAM read launched last cycle missed a write landing on the same address; substitute the written word.
  assign w_rdata      = r_fwd_hit ? r_fwd_dat : r_ram_q;
  assign w_rd_muted   = r_s1_primed ? w_rdata : '0;

`ifdef ECHO_DELAY_FEEDBACK_EN
  logic signed [WIDTH-1:0] w_fb;
  logic        [WIDTH:0]   w_sum;
  logic        [WIDTH-1:0] w_sat;

  assign w_fb    = $signed(w_rd_muted) >>> FB_SHIFT;
  assign w_sum   = {r_s1_din[WIDTH-1], r_s1_din} + {w_fb[WIDTH-1], w_fb};
  assign w_sat   = (w_sum[WIDTH] != w_sum[WIDTH-1]) ? {w_sum[WIDTH], {(WIDTH-1){~w_sum[WIDTH]}}}
                                                    : w_sum[WIDTH-1:0];
  assign w_wdata = r_s1_bypass ? r_s1_din : w_sat;
`else
  assign w_wdata = r_s1_din;
`endif

  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_s1_ptr] <= w_wdata;
    end
    if (i_en) begin
      r_ram_q <= r_mem[w_rd_addr];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr     <= '0;
      r_fill       <= '0;
      r_s1_vld     <= 1'b0;
      r_s1_din     <= '0;
      r_s1_ptr     <= '0;
      r_s1_primed  <= 1'b0;
      r_s1_bypass  <= 1'b0;
      r_fwd_hit    <= 1'b0;
      r_fwd_dat    <= '0;
      o_dout       <= '0;
      o_dout_valid <= 1'b0;
      o_primed     <= 1'b0;
    end else begin
      r_s1_vld     <= i_en;
      o_dout_valid <= r_s1_vld;
      if (i_en) begin
        r_wr_ptr    <= r_wr_ptr + ADDR_WIDTH'(1);
        if (r_fill != FILL_MAX) begin
          r_fill <= r_fill + ADDR_WIDTH'(1);
        end
        r_s1_din    <= i_din;
        r_s1_ptr    <= r_wr_ptr;
        r_s1_primed <= w_primed_now;
        r_s1_bypass <= (i_offset == '0);
        r_fwd_hit   <= w_wr_en && (w_rd_addr == r_s1_ptr);
        r_fwd_dat   <= w_wdata;
      end
      if (r_s1_vld) begin
        o_dout   <= r_s1_bypass ? r_s1_din : w_rd_muted;
        o_primed <= r_s1_primed;
      end
    end
  end

endmodule

// File: tb/tb_echo_delay.sv
// Scoreboard bench for echo_delay (ADDR_WIDTH=4): directed strobes push expected outputs, a negedge monitor pops and compares.
module tb_echo_delay;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [W-1:0]  din;
  logic [AW-1:0] offset;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          primed;

  always #5 clk = ~clk;

  echo_delay #(.WIDTH(W), .ADDR_WIDTH(AW), .FB_SHIFT(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_din(din), .i_offset(offset),
    .o_dout(dout), .o_dout_valid(dout_valid), .o_primed(primed)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_d_q[$];
  logic         exp_p_q[$];
  int           exp_c_q[$];
  logic [W-1:0] hold_d  = '0;
  logic         hold_p  = 1'b0;
  bit           mon_en  = 1'b0;

  int fb_imp[9] = '{0, 0, 64, 0, 32, 0, 16, 0, 8};
  int fb_o1[5]  = '{0, 64, 32, 16, 8};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic strobe(input logic [W-1:0] d, input logic [AW-1:0] off,
                        input logic [W-1:0] ed, input logic ep);
    @(posedge clk); #1;
    en = 1'b1; din = d; offset = off;
    exp_d_q.push_back(ed);
    exp_p_q.push_back(ep);
    exp_c_q.push_back(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      en = 1'b0;
    end
  endtask

  // One reset cycle, optionally with a strobe present; anything still in flight is dropped.
  task automatic do_reset(input logic with_en);
    @(posedge clk); #1;
    rst = 1'b1; en = with_en; din = W'(99);
    @(posedge clk); #1;
    chk("rst_dout", int'(dout), 0);
    chk("rst_primed", int'(primed), 0);
    chk("rst_valid", int'(dout_valid), 0);
    rst = 1'b0; en = 1'b0;
    exp_d_q.delete(); exp_p_q.delete(); exp_c_q.delete();
    hold_d = '0; hold_p = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (dout_valid) begin
        checks++;
        if (exp_d_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: got dout=%0d primed=%0b with no pending sample (t=%0t)", dout, primed, $time);
        end else begin
          logic [W-1:0] ed;
          logic         ep;
          int           ec;
          ed = exp_d_q.pop_front();
          ep = exp_p_q.pop_front();
          ec = exp_c_q.pop_front();
          if (dout !== ed || primed !== ep || (cyc - ec) != 2) begin
            errors++;
            $display("FAIL sample: got dout=%0d primed=%0b latency=%0d expected dout=%0d primed=%0b latency=2 (t=%0t)",
                     dout, primed, cyc - ec, ed, ep, $time);
          end
          hold_d = ed;
          hold_p = ep;
        end
      end else begin
        checks++;
        if (dout !== hold_d || primed !== hold_p) begin
          errors++;
          $display("FAIL hold: got dout=%0d primed=%0b expected dout=%0d primed=%0b (t=%0t)",
                   dout, primed, hold_d, hold_p, $time);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; din = '0; offset = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_dout", int'(dout), 0);
    chk("init_primed", int'(primed), 0);
    chk("init_valid", int'(dout_valid), 0);
    rst = 1'b0;
    mon_en = 1'b1;

`ifndef ECHO_DELAY_FEEDBACK_EN
    // Basic delay, offset 3
    for (int k = 1; k <= 8; k++)
      strobe(W'(k), AW'(3), (k >= 4) ? W'(k - 3) : W'(0), k >= 4);
    idle(3);
    do_reset(1'b0);

    // Collision forwarding at offset 1, then bypass at offset 0, then back to offset 1
    strobe(W'(5), AW'(1), W'(0), 1'b0);
    strobe(W'(6), AW'(1), W'(5), 1'b1);
    strobe(W'(7), AW'(1), W'(6), 1'b1);
    strobe(W'(5), AW'(0), W'(5), 1'b1);
    strobe(W'(6), AW'(0), W'(6), 1'b1);
    strobe(W'(7), AW'(0), W'(7), 1'b1);
    strobe(W'(9), AW'(1), W'(7), 1'b1);
    idle(3);
    do_reset(1'b0);

    // Maximum offset across two pointer wraps
    for (int k = 0; k < 40; k++)
      strobe(W'(k), AW'(15), (k >= 15) ? W'(k - 15) : W'(0), k >= 15);
    idle(3);
    do_reset(1'b0);

    // Sparse strobes
    strobe(W'(10), AW'(2), W'(0), 1'b0);
    idle(3);
    strobe(W'(20), AW'(2), W'(0), 1'b0);
    idle(3);
    strobe(W'(30), AW'(2), W'(10), 1'b1);
    idle(4);
    do_reset(1'b0);

    // Reset mid-stream with a strobe in the reset cycle
    for (int k = 1; k <= 10; k++)
      strobe(W'(k), AW'(2), (k >= 3) ? W'(k - 2) : W'(0), k >= 3);
    do_reset(1'b1);
    strobe(W'(11), AW'(2), W'(0), 1'b0);
    strobe(W'(12), AW'(2), W'(0), 1'b0);
    strobe(W'(13), AW'(2), W'(11), 1'b1);
    strobe(W'(14), AW'(2), W'(12), 1'b1);
`else
    // Impulse response, offset 2
    for (int i = 0; i < 9; i++)
      strobe((i == 0) ? W'(64) : W'(0), AW'(2), W'(fb_imp[i]), i >= 2);
    idle(3);
    do_reset(1'b0);

    // Positive saturation
    for (int i = 0; i < 8; i++)
      strobe(W'(127), AW'(2), (i >= 2) ? W'(127) : W'(0), i >= 2);
    idle(3);
    do_reset(1'b0);

    // Negative saturation
    for (int i = 0; i < 5; i++)
      strobe(8'h80, AW'(2), (i >= 2) ? 8'h80 : 8'h00, i >= 2);
    idle(3);
    do_reset(1'b0);

    // Feedback through the forwarding path, then bypass leaves feedback out of the stored word
    for (int i = 0; i < 5; i++)
      strobe((i == 0) ? W'(64) : W'(0), AW'(1), W'(fb_o1[i]), i >= 1);
    strobe(W'(10), AW'(0), W'(10), 1'b1);
    strobe(W'(0), AW'(1), W'(10), 1'b1);
`endif

    idle(4);
    chk("drain_pending", exp_d_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/echo_delay.md
# echo_delay

Parametrised circular-buffer delay line for the signal-generation/audio path: one sample is written per `en` strobe and one sample delayed by a runtime `offset` is read. It extends the fixed 9-bit delay block with parametrised width and depth, write-first forwarding for short offsets, priming/mute tracking, and an optional feedback echo path. It sits between the sampled mic/generator source and the output DAC/VBuddy plot stage.

## Interface
- `WIDTH`, default 8: sample width, signed two's complement.
- `ADDR_WIDTH`, default 9: buffer depth is 2^ADDR_WIDTH; the maximum usable offset is 2^ADDR_WIDTH-1.
- `FB_SHIFT`, default 1: feedback attenuation, arithmetic right shift. Used only with feedback compiled in.
- `clk` in 1: the single clock; every register updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: sample strobe; one sample is processed per high cycle.
- `din` in WIDTH: input sample, captured when `en`=1.
- `offset` in ADDR_WIDTH: delay in samples, sampled when `en`=1.
- `dout` out WIDTH: delayed sample; reset value 0.
- `dout_valid` out 1: one-cycle pulse per processed strobe; reset value 0.
- `primed` out 1: qualifies the current `dout`; 1 means real history, 0 means muted. Reset value 0.

## Operation
- **Write pointer `wr_ptr`** (ADDR_WIDTH bits):
  - Reset value 0.
  - Increments by 1 per strobe, modulo 2^ADDR_WIDTH.
  - Wraps 2^ADDR_WIDTH-1 → 0 with no discontinuity.
- **Read address:** `wr_ptr - offset`, modulo 2^ADDR_WIDTH. Unsigned wrap is required.
- **Fill counter:**
  - Counts writes since reset.
  - Saturates at 2^ADDR_WIDTH-1.
  - A strobe is primed when fill ≥ `offset`, evaluated before that strobe's own write.
  - RAM is never cleared; unprimed outputs are forced to 0.
- **`offset`=0:**
  - The stage-1 `din` bypasses to `dout`.
  - `primed`=1.
  - Feedback is disabled for that sample.
- **Collision:** when a read address equals the address being written in the same cycle, the read returns the data being written (write-first forwarding). This happens with `offset`=1 and back-to-back strobes.
- **Offset change:** takes effect on the next strobe. No mute, no flush. The fill rule is re-evaluated against the new offset.
- **`en` low:**
  - Pointer, fill counter and `dout` hold.
  - `dout_valid` stays 0.
- **Reset mid-operation:**
  - In-flight samples are dropped.
  - No RAM write occurs in any cycle with `rst`=1.
  - All state returns to reset values.

## Timing
- **Cycle t** (`en`=1):
  - RAM read issued.
  - `din`, `wr_ptr` and the primed flag are registered into stage 1.
  - `wr_ptr` and fill update.
- **Cycle t+1:**
  - Read data is available, forwarded if it collides.
  - Write data is computed and written at the stage-1 pointer at the end of t+1.
  - `dout`/`primed` are registered.
- **Cycle t+2:** `dout_valid`=1 with the new `dout`/`primed`. Latency is 2 cycles.
- **Throughput:** one strobe per cycle. `en` may be high continuously.
- `dout` and `primed` hold their values between pulses.

## Configuration
- **`ECHO_DELAY_FEEDBACK_EN` defined:**
  - Write data = sat(din + (rdata >>> FB_SHIFT)).
  - rdata is the delayed sample read for that same strobe, after the mute rule is applied (unprimed → 0).
  - The addition saturates to the signed WIDTH range [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- **Undefined:**
  - Write data = din.
  - No adder or saturation logic is present.

## Test plan
- **Basic delay:** no feedback, `offset`=3, `en` held high, din=1,2,3,… → first `dout_valid` 2 cycles after the first strobe. Outputs are 0,0,0 with `primed`=0, then 1,2,3,… with `primed`=1.
- **Bypass and collision:**
  - `offset`=0, din=5,6,7 → `dout` 5,6,7 at latency 2, `primed`=1.
  - `offset`=1, back-to-back strobes → 0,5,6 (forwarding exercised).
- **Wrap-around:** `ADDR_WIDTH`=4, `offset`=15, 40 consecutive samples din=k → sample k outputs k−15 for k≥15, including across two pointer wraps.
- **Sparse strobes:** `en` every 4th cycle, `offset`=2, din=10,20,30 → outputs 0,0,10 as single-cycle `dout_valid` pulses. `dout` holds between pulses.
- **Reset mid-stream:** run 10 samples at `offset`=2, assert `rst` for 1 cycle →
  - all outputs read 0 during and after reset;
  - a strobe present in the reset cycle is not written;
  - the next 2 outputs are muted (`primed`=0).
- **Feedback** (macro defined, `FB_SHIFT`=1, `offset`=2):
  - Impulse 64 then zeros → outputs 0,0,64,0,32,0,16,0,8.
  - Constant din=127 → stored values saturate at 127 with no wrap to negative.
